// File: rtl/axi4_lite_rd_buffer.sv
// AXI4-lite read-channel buffer: queues AR requests toward the downstream slave
// and R beats back toward the upstream master, limits outstanding transactions,
// and drops (and flags) R beats that arrive with nothing issued.
module axi4_lite_rd_buffer #(
    parameter int unsigned A        = 32,
    parameter int unsigned N        = 4,
    parameter int unsigned AR_DEPTH = 4,
    parameter int unsigned R_DEPTH  = 4,
    parameter int unsigned MAX_OUT  = 4
) (
    input  logic           aclk,
    input  logic           areset,
    input  logic [A-1:0]   s_araddr,
    input  logic           s_arvalid,
    output logic           s_arready,
    output logic [8*N-1:0] s_rdata,
    output logic [1:0]     s_rresp,
    output logic           s_rvalid,
    input  logic           s_rready,
    output logic [A-1:0]   m_araddr,
    output logic           m_arvalid,
    input  logic           m_arready,
    input  logic [8*N-1:0] m_rdata,
    input  logic [1:0]     m_rresp,
    input  logic           m_rvalid,
    output logic           m_rready,
    output logic [7:0]     outstanding,
    output logic           err_unexp_r
);

    localparam int unsigned DW   = 8 * N;
    localparam int unsigned RW   = DW + 2;
    localparam int unsigned ARPW = $clog2(AR_DEPTH);
    localparam int unsigned ARCW = $clog2(AR_DEPTH + 1);
    localparam int unsigned RPW  = $clog2(R_DEPTH);
    localparam int unsigned RCW  = $clog2(R_DEPTH + 1);

    localparam logic [ARCW-1:0] ArFullCnt = ARCW'(AR_DEPTH);
    localparam logic [RCW-1:0]  RFullCnt  = RCW'(R_DEPTH);
    localparam logic [7:0]      MaxOut    = 8'(MAX_OUT);

    // Storage
    logic [A-1:0]    ar_mem_q [AR_DEPTH];
    logic [RW-1:0]   r_mem_q  [R_DEPTH];

    logic [ARPW-1:0] ar_wptr_q, ar_rptr_q;
    logic [ARCW-1:0] ar_cnt_q, ar_cnt_d;
    logic [RPW-1:0]  r_wptr_q, r_rptr_q;
    logic [RCW-1:0]  r_cnt_q, r_cnt_d;

    logic [7:0]      outstanding_q, outstanding_d;
    logic [7:0]      issued_q, issued_d;
    logic            err_q, err_d;

    logic            ar_full, ar_empty, r_full, r_empty;
    logic            ar_push, ar_pop, r_push, r_pop;
    logic            m_r_xfer, unexp_r;

    // Handshakes, status flags and head-of-queue outputs
    always_comb begin
        ar_full     = (ar_cnt_q == ArFullCnt);
        ar_empty    = (ar_cnt_q == '0);
        r_full      = (r_cnt_q == RFullCnt);
        r_empty     = (r_cnt_q == '0);

        s_arready   = !ar_full && (outstanding_q < MaxOut);
        m_arvalid   = !ar_empty;
        m_araddr    = ar_mem_q[ar_rptr_q];
        m_rready    = !r_full;
        s_rvalid    = !r_empty;
        {s_rdata, s_rresp} = r_mem_q[r_rptr_q];
        outstanding = outstanding_q;
        err_unexp_r = err_q;

        ar_push  = s_arvalid && s_arready;
        ar_pop   = m_arvalid && m_arready;
        m_r_xfer = m_rvalid && m_rready;
        // An AR leaving in the same cycle covers a beat that arrives with issued==0.
        unexp_r  = m_r_xfer && (issued_q == '0) && !ar_pop;
        r_push   = m_r_xfer && !unexp_r;
        r_pop    = s_rvalid && s_rready;
    end

    // Next-state for occupancy, transaction counters and sticky error
    always_comb begin
        ar_cnt_d      = ar_cnt_q;
        r_cnt_d       = r_cnt_q;
        outstanding_d = outstanding_q;
        issued_d      = issued_q;
        err_d         = err_q || unexp_r;

        if (ar_push && !ar_pop) begin
            ar_cnt_d = ar_cnt_q + ARCW'(1);
        end else if (!ar_push && ar_pop) begin
            ar_cnt_d = ar_cnt_q - ARCW'(1);
        end

        if (r_push && !r_pop) begin
            r_cnt_d = r_cnt_q + RCW'(1);
        end else if (!r_push && r_pop) begin
            r_cnt_d = r_cnt_q - RCW'(1);
        end

        if (ar_push && !r_pop) begin
            outstanding_d = outstanding_q + 8'd1;
        end else if (!ar_push && r_pop) begin
            outstanding_d = outstanding_q - 8'd1;
        end

        if (ar_pop && !r_push) begin
            issued_d = issued_q + 8'd1;
        end else if (!ar_pop && r_push) begin
            issued_d = issued_q - 8'd1;
        end
    end

    // Control state: pointers, counts and flags, cleared asynchronously
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            ar_wptr_q     <= '0;
            ar_rptr_q     <= '0;
            ar_cnt_q      <= '0;
            r_wptr_q      <= '0;
            r_rptr_q      <= '0;
            r_cnt_q       <= '0;
            outstanding_q <= '0;
            issued_q      <= '0;
            err_q         <= 1'b0;
        end else begin
            if (ar_push) ar_wptr_q <= ar_wptr_q + ARPW'(1);
            if (ar_pop)  ar_rptr_q <= ar_rptr_q + ARPW'(1);
            if (r_push)  r_wptr_q  <= r_wptr_q + RPW'(1);
            if (r_pop)   r_rptr_q  <= r_rptr_q + RPW'(1);
            ar_cnt_q      <= ar_cnt_d;
            r_cnt_q       <= r_cnt_d;
            outstanding_q <= outstanding_d;
            issued_q      <= issued_d;
            err_q         <= err_d;
        end
    end

    // Payload storage; only written on an accepted transfer so idle X never enters
    always_ff @(posedge aclk) begin
        if (ar_push) ar_mem_q[ar_wptr_q] <= s_araddr;
        if (r_push)  r_mem_q[r_wptr_q]   <= {m_rdata, m_rresp};
    end

endmodule

// File: tb/tb_axi4_lite_rd_buffer.sv
// Scoreboard bench for axi4_lite_rd_buffer: a negedge monitor models queue
// occupancy and counters, and checks every upstream/downstream payload in order.
module tb_axi4_lite_rd_buffer;

    localparam int unsigned A   = 32;
    localparam int unsigned N   = 4;
    localparam int unsigned ARD = 4;
    localparam int unsigned RD  = 4;
    localparam int unsigned MO  = 4;

    logic           aclk = 1'b0;
    logic           areset;
    logic [A-1:0]   s_araddr;
    logic           s_arvalid;
    logic           s_arready;
    logic [8*N-1:0] s_rdata;
    logic [1:0]     s_rresp;
    logic           s_rvalid;
    logic           s_rready;
    logic [A-1:0]   m_araddr;
    logic           m_arvalid;
    logic           m_arready;
    logic [8*N-1:0] m_rdata;
    logic [1:0]     m_rresp;
    logic           m_rvalid;
    logic           m_rready;
    logic [7:0]     outstanding;
    logic           err_unexp_r;

    axi4_lite_rd_buffer #(
        .A(A), .N(N), .AR_DEPTH(ARD), .R_DEPTH(RD), .MAX_OUT(MO)
    ) dut (
        .aclk(aclk), .areset(areset),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .outstanding(outstanding), .err_unexp_r(err_unexp_r)
    );

    always #5 aclk = ~aclk;

    int unsigned    n_chk  = 0;
    int unsigned    n_pass = 0;

    // Scoreboard queues double as the expected FIFO occupancy.
    logic [A-1:0]   ar_q[$];
    logic [8*N+1:0] r_q[$];
    int unsigned    mod_out = 0;
    int unsigned    mod_iss = 0;
    logic           mod_err = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Monitor: checks outputs against the model, then applies the transfers of the coming edge
    always @(negedge aclk) begin
        if (areset) begin
            ar_q.delete();
            r_q.delete();
            mod_out = 0;
            mod_iss = 0;
            mod_err = 1'b0;
        end else begin
            bit s_ar, m_ar, s_r, m_r, unexp;
            check("s_arready", s_arready, (ar_q.size() < ARD) && (mod_out < MO));
            check("m_arvalid", m_arvalid, ar_q.size() != 0);
            check("m_rready", m_rready, r_q.size() < RD);
            check("s_rvalid", s_rvalid, r_q.size() != 0);
            check("outstanding", outstanding, mod_out);
            check("err_unexp_r", err_unexp_r, mod_err);
            s_ar = s_arvalid && s_arready;
            m_ar = m_arvalid && m_arready;
            s_r  = s_rvalid && s_rready;
            m_r  = m_rvalid && m_rready;
            if (m_ar && ar_q.size() > 0) check("m_araddr", m_araddr, ar_q.pop_front());
            if (s_r && r_q.size() > 0) check("s_r payload", {s_rdata, s_rresp}, r_q.pop_front());
            unexp = m_r && (mod_iss == 0) && !m_ar;
            if (m_r && !unexp) r_q.push_back({m_rdata, m_rresp});
            if (unexp) mod_err = 1'b1;
            if (s_ar) ar_q.push_back(s_araddr);
            mod_out = mod_out + (s_ar ? 1 : 0) - (s_r ? 1 : 0);
            mod_iss = mod_iss + (m_ar ? 1 : 0) - ((m_r && !unexp) ? 1 : 0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    // Raise s_arvalid and hold until accepted or budget expires; valid is left high.
    task automatic ar_req(input logic [A-1:0] addr, input int budget, output bit ok);
        s_araddr  = addr;
        s_arvalid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge aclk);
            ok = s_arready;
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic ar_idle();
        s_arvalid = 1'b0;
        s_araddr  = 'x;
    endtask

    task automatic r_push(input logic [8*N-1:0] data, input logic [1:0] resp, input int budget,
                          output bit ok);
        m_rdata  = data;
        m_rresp  = resp;
        m_rvalid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge aclk);
            ok = m_rready;
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic r_idle();
        m_rvalid = 1'b0;
        m_rdata  = 'x;
        m_rresp  = 'x;
    endtask

    task automatic single_read(input logic [A-1:0] addr, input logic [8*N-1:0] data,
                               input logic [1:0] resp);
        bit ok;
        ar_req(addr, 8, ok);
        check("read ar accepted", ok, 1'b1);
        ar_idle();
        tick(2);
        r_push(data, resp, 8, ok);
        check("read r accepted", ok, 1'b1);
        r_idle();
    endtask

    task automatic drain(input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            tick(1);
            done = (ar_q.size() == 0) && (r_q.size() == 0) && (mod_out == 0);
        end
        check("drain timeout", done, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int unsigned n_acc;

        areset    = 1'b1;
        s_arvalid = 1'b0;
        s_araddr  = 'x;
        s_rready  = 1'b1;
        m_arready = 1'b1;
        r_idle();
        #12;
        check("rst s_arready", s_arready, 1'b1);
        check("rst m_rready", m_rready, 1'b1);
        check("rst s_rvalid", s_rvalid, 1'b0);
        check("rst m_arvalid", m_arvalid, 1'b0);
        check("rst outstanding", outstanding, 8'd0);
        check("rst err", err_unexp_r, 1'b0);
        @(posedge aclk);
        #1 areset = 1'b0;
        tick(1);

        // Single read with directed latency checks
        ar_req(32'h0000_1000, 4, ok);
        check("t1 accepted", ok, 1'b1);
        ar_idle();
        check("t1 outstanding", outstanding, 8'd1);
        check("t1 m_arvalid", m_arvalid, 1'b1);
        tick(2);
        r_push(32'hDEAD_BEEF, 2'd0, 4, ok);
        r_idle();
        check("t1 s_rvalid", s_rvalid, 1'b1);
        check("t1 s_rdata", s_rdata, 32'hDEAD_BEEF);
        check("t1 s_rresp", s_rresp, 2'd0);
        tick(1);
        check("t1 outstanding end", outstanding, 8'd0);
        drain(20);

        // Outstanding limit
        s_rready = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            ar_req(32'h100 + 32'(i) * 4, 3, ok);
            if (!ok) break;
            n_acc++;
        end
        check("t2 accepted", n_acc, 4);
        check("t2 s_arready", s_arready, 1'b0);
        check("t2 outstanding", outstanding, 8'd4);
        r_push(32'hA0, 2'd1, 4, ok);
        r_idle();
        s_rready = 1'b1;
        tick(1);
        s_rready = 1'b0;
        check("t2 s_arready after pop", s_arready, 1'b1);
        ar_req(32'h110, 3, ok);
        check("t2 5th accepted", ok, 1'b1);
        ar_idle();
        tick(2);
        s_rready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            r_push(32'hA1 + 32'(i), 2'(i), 6, ok);
            check("t2 r accepted", ok, 1'b1);
        end
        r_idle();
        drain(20);

        // R backpressure
        s_rready = 1'b0;
        for (int i = 0; i < 4; i++) ar_req(32'h200 + 32'(i) * 4, 4, ok);
        ar_idle();
        tick(3);
        for (int i = 0; i < 4; i++) begin
            r_push(32'hB0 + 32'(i), 2'(3 - i), 4, ok);
            check("t3 r accepted", ok, 1'b1);
        end
        r_idle();
        check("t3 m_rready full", m_rready, 1'b0);
        s_rready = 1'b1;
        tick(1);
        check("t3 m_rready after pop", m_rready, 1'b1);
        drain(20);

        // AR backpressure and in-order issue
        m_arready = 1'b0;
        for (int i = 1; i <= 4; i++) ar_req(32'(i) * 32'h10, 4, ok);
        ar_idle();
        check("t4 s_arready full", s_arready, 1'b0);
        check("t4 head", m_araddr, 32'h10);
        m_arready = 1'b1;
        tick(1);
        check("t4 addr 2", m_araddr, 32'h20);
        tick(1);
        check("t4 addr 3", m_araddr, 32'h30);
        tick(1);
        check("t4 addr 4", m_araddr, 32'h40);
        tick(1);
        for (int i = 0; i < 4; i++) r_push(32'hC0 + 32'(i), 2'd2, 4, ok);
        r_idle();
        drain(20);

        // Unexpected R beat is dropped and the flag sticks
        r_push(32'hBAD0_BAD0, 2'd3, 4, ok);
        r_idle();
        tick(1);
        check("t5 err set", err_unexp_r, 1'b1);
        check("t5 s_rvalid", s_rvalid, 1'b0);
        single_read(32'h0000_2000, 32'h1234_5678, 2'd2);
        drain(20);
        check("t5 err sticky", err_unexp_r, 1'b1);

        // Asynchronous reset mid-cycle with work in flight
        s_rready = 1'b0;
        ar_req(32'h300, 4, ok);
        ar_req(32'h304, 4, ok);
        ar_idle();
        tick(3);
        r_push(32'hD0, 2'd0, 4, ok);
        r_idle();
        tick(1);
        check("t6 pre outstanding", outstanding, 8'd2);
        check("t6 pre s_rvalid", s_rvalid, 1'b1);
        @(posedge aclk);
        #3 areset = 1'b1;
        #1;
        check("t6 s_rvalid", s_rvalid, 1'b0);
        check("t6 outstanding", outstanding, 8'd0);
        check("t6 err", err_unexp_r, 1'b0);
        check("t6 m_arvalid", m_arvalid, 1'b0);
        check("t6 s_arready", s_arready, 1'b1);
        @(posedge aclk);
        #1 areset = 1'b0;
        s_rready = 1'b1;
        tick(1);
        single_read(32'h0000_3000, 32'hCAFE_F00D, 2'd1);
        drain(20);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
